// File: rtl/f4_pkg.sv
// Constants shared by the F-4 fetch controller and the memory model.
package f4_pkg;

   localparam int F4_AW    = 5;
   localparam int F4_DW    = 5;
   localparam int F4_NPOS  = 1 << F4_AW;
   localparam int LONG_BIT = F4_DW - 1;

   // A fetch at LAST_ADDR has no room for any instruction; a long one at
   // PENULT_ADDR would need a word past the end of memory.
   localparam logic [F4_AW-1:0] F4_LAST_ADDR   = F4_AW'(F4_NPOS - 1);
   localparam logic [F4_AW-1:0] F4_PENULT_ADDR = F4_AW'(F4_NPOS - 2);

   typedef logic [2:0] f4_state_t;

   localparam f4_state_t ST_IDLE  = 3'd0;
   localparam f4_state_t ST_ISSUE = 3'd1;
   localparam f4_state_t ST_CAPT  = 3'd2;
   localparam f4_state_t ST_HOLD  = 3'd3;
   localparam f4_state_t ST_STORE = 3'd4;
   localparam f4_state_t ST_FAULT = 3'd5;

   function automatic logic is_long(input logic [F4_DW-1:0] w0);
      return w0[LONG_BIT];
   endfunction

endpackage

// File: rtl/f4_fetch.sv
// F-4 instruction fetch and memory-port controller: owns the PC, assembles
// 1/2-word instructions from double-word reads and sequences core stores.
module f4_fetch
   import f4_pkg::*;
(
   input  logic               clk,
   input  logic               rstn,
   input  logic               run,
   input  logic               jmp_en,
   input  logic [F4_AW-1:0]   jmp_addr,
   input  logic               st_req,
   input  logic [F4_AW-1:0]   st_addr,
   input  logic [F4_DW-1:0]   st_data,
   output logic               st_ack,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [F4_DW-1:0]   instr_w0,
   output logic [F4_DW-1:0]   instr_w1,
   output logic               instr_long,
   output logic [F4_AW-1:0]   instr_pc,
   output logic               fault,
   output logic               mem_rw,
   output logic [F4_AW-1:0]   mem_addr,
   output logic [F4_DW-1:0]   mem_din,
   input  logic [2*F4_DW-1:0] mem_dout,
   output f4_state_t          dbg_state
);

   f4_state_t        state;
   logic [F4_AW-1:0] pc;

   logic             handshake;
   logic             decide;
   logic             st_go;
   logic [F4_DW-1:0] cap_w0;
   logic [F4_DW-1:0] cap_w1;
   logic             cap_long;
   logic             cap_stale;

   // Handshake: an instruction transfers on a rising edge where instr_valid
   // and instr_ready are both high; while valid is high and ready low, every
   // instr_* output holds. A jmp_en in the same cycle cancels the transfer.
   assign handshake = instr_valid && instr_ready;
   assign decide    = (state == ST_IDLE) ||
                      ((state == ST_HOLD) && handshake && !jmp_en);

   // The request is still high in the ack cycle; do not start it twice.
   assign st_go     = st_req && !st_ack;

   assign cap_w0    = mem_dout[F4_DW-1:0];
   assign cap_w1    = mem_dout[2*F4_DW-1:F4_DW];
   assign cap_long  = is_long(cap_w0);
   assign cap_stale = cap_long && (pc == F4_PENULT_ADDR);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         pc          <= '0;
         mem_rw      <= 1'b1;
         mem_addr    <= '0;
         mem_din     <= '0;
         st_ack      <= 1'b0;
         instr_valid <= 1'b0;
         instr_w0    <= '0;
         instr_w1    <= '0;
         instr_long  <= 1'b0;
         instr_pc    <= '0;
         fault       <= 1'b0;
      end else begin
         st_ack <= 1'b0;
         if (decide) begin
            instr_valid <= 1'b0;
            if (st_go) begin
               mem_rw   <= 1'b0;
               mem_addr <= st_addr;
               mem_din  <= st_data;
               state    <= ST_STORE;
            end else if (jmp_en) begin
               pc    <= jmp_addr;
               fault <= 1'b0;
               state <= ST_IDLE;
            end else if (run) begin
               if (pc == F4_LAST_ADDR) begin
                  fault <= 1'b1;
                  state <= ST_FAULT;
               end else begin
                  mem_rw   <= 1'b1;
                  mem_addr <= pc;
                  state    <= ST_ISSUE;
               end
            end else begin
               state <= ST_IDLE;
            end
         end else begin
            case (state)
               ST_ISSUE: begin
                  if (jmp_en) begin
                     pc    <= jmp_addr;
                     fault <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_CAPT;
                  end
               end
               ST_CAPT: begin
                  if (jmp_en) begin
                     pc    <= jmp_addr;
                     fault <= 1'b0;
                     state <= ST_IDLE;
                  end else if (cap_stale) begin
                     fault <= 1'b1;
                     state <= ST_FAULT;
                  end else begin
                     instr_w0    <= cap_w0;
                     instr_w1    <= cap_long ? cap_w1 : '0;
                     instr_long  <= cap_long;
                     instr_pc    <= pc;
                     pc          <= pc + (cap_long ? F4_AW'(2) : F4_AW'(1));
                     instr_valid <= 1'b1;
                     state       <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  // Reaching here with jmp_en means the held word is dropped,
                  // even if the core was accepting it this cycle.
                  if (jmp_en) begin
                     instr_valid <= 1'b0;
                     pc          <= jmp_addr;
                     fault       <= 1'b0;
                     state       <= ST_IDLE;
                  end
               end
               ST_STORE: begin
                  st_ack <= 1'b1;
                  mem_rw <= 1'b1;
                  state  <= ST_IDLE;
               end
               ST_FAULT: begin
                  if (jmp_en) begin
                     pc    <= jmp_addr;
                     fault <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   a_rw_only_in_store: assert property (@(posedge clk) disable iff (!rstn)
      (!mem_rw) == (state == ST_STORE));

   a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
      (instr_valid && !instr_ready && !jmp_en) |=>
      (instr_valid && $stable({instr_w0, instr_w1, instr_long, instr_pc})));

endmodule

// File: doc/f4_fetch.md
# f4_fetch

Instruction fetch and memory-port controller for the F-4 processor. Drives the single-port F-4 memory, whose reads return two consecutive words, as its only initiator. Maintains the program counter, assembles 1- or 2-word instructions from each read, and hands them to the core over a valid/ready handshake. Also sequences core store requests onto the same port and raises a fault on fetches past the end of memory.

## Interface
- AW, 5, memory address width; NPOS = 2**AW words
- DW, 5, memory word width
- LONG_BIT, DW-1, bit of word0 that marks a 2-word instruction
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- run  in  1  level; fetching proceeds while high
- jmp_en  in  1  one-cycle pulse: load PC from jmp_addr
- jmp_addr  in  AW  jump target
- st_req  in  1  store request, held until st_ack
- st_addr  in  AW  store address
- st_data  in  DW  store data
- st_ack  out  1  one-cycle pulse, store issued
- instr_valid  out  1  instruction on instr_* is valid
- instr_ready  in  1  core accepts instruction
- instr_w0  out  DW  first word (opcode)
- instr_w1  out  DW  second word; zero for 1-word instructions
- instr_long  out  1  instruction is 2 words
- instr_pc  out  AW  address of instr_w0
- fault  out  1  sticky fetch-past-end flag
- mem_rw  out  1  1 = read, 0 = write (registered)
- mem_addr  out  AW  memory address (registered)
- mem_din  out  DW  write data (registered)
- mem_dout  in  2*DW  {word[addr+1], word[addr]}, valid the cycle after the read edge

## Operation
- States: IDLE, ISSUE, CAPT, HOLD, STORE, FAULT.
- Reset: state IDLE, PC=0, mem_rw=1, mem_addr=0, mem_din=0, st_ack=0, instr_valid=0, instr_w0/w1/pc=0, instr_long=0, fault=0.
- Decision point: IDLE, or HOLD in a cycle where the handshake completes. Priority there is st_req, then jmp_en, then fetch (run=1).
- Store: register mem_rw=0, mem_addr=st_addr, mem_din=st_data, and go to STORE. In STORE, pulse st_ack, restore mem_rw=1, and return to IDLE. The PC is unchanged.
- Jump: PC<=jmp_addr and fault<=0. From FAULT this is the only exit, and it goes to IDLE.
- Fetch: if PC==NPOS-1, set fault and go to FAULT with no memory access. Otherwise register mem_addr=PC, mem_rw=1, and go to ISSUE.
- ISSUE goes to CAPT unconditionally. The memory samples the address on this edge.
- CAPT: take w0=mem_dout[DW-1:0]. long=w0[LONG_BIT].
  - If long and PC==NPOS-2, the high word is stale: set fault, go to FAULT, and do not present the instruction.
  - Otherwise set instr_w0=w0, instr_w1=(long ? mem_dout[2DW-1:DW] : 0), instr_long=long, instr_pc=PC, and PC<=PC+1+long (mod NPOS). Set instr_valid=1 and go to HOLD.
- HOLD: outputs stay stable while instr_valid && !instr_ready. On handshake, instr_valid drops the next cycle unless a new fetch is already completing.
- jmp_en in HOLD, ISSUE or CAPT: any in-flight or held instruction is discarded. instr_valid<=0, PC<=jmp_addr, go to IDLE. jmp_en has priority over a simultaneous handshake; the instruction is not counted as consumed.
- st_req outside decision points waits; it is never dropped.
- run=0 only stops new fetches. An in-flight fetch completes to HOLD.

## Timing
- Fetch latency: ISSUE at cycle t, CAPT at t+1, instr_valid high at t+2. Back-to-back throughput is 1 instruction per 3 cycles with instr_ready held high.
- Store: st_req seen at a decision point gives mem_rw=0 for exactly 1 cycle and st_ack 1 cycle later.
- mem_rw is low only during STORE. Every other cycle, including reset, reads.
- PC wrap: a 1-word instruction at NPOS-1 is never fetched (fault). A 2-word instruction at NPOS-3 leaves PC=NPOS-1.
- Reset mid-operation: the next cycle shows reset values. A pending store is dropped, with no st_ack.

## Structure
- Shared package f4_pkg holds:
  - the state enum;
  - LONG_BIT;
  - the NPOS-1 and NPOS-2 boundary constants, which the memory model shares.
- Single module, no sub-modules. The PC is a plain register inside the FSM.

## Test plan
- AW=5, DW=5, memory preloaded with 1-word 0x03 at 0 and 2-word 0x11,0x07 at 1, ready=1, run=1 -> instr (0x03,0,pc0,long0), then (0x11,0x07,pc1,long1); PC=3; valid 3 cycles apart.
- ready=0 for 5 cycles while valid -> outputs frozen, no new mem_addr.
- st_req addr 9 data 0x1A during HOLD, then fetch from 9 -> exactly one mem_rw=0 cycle and one st_ack; instr_w0=0x1A.
- jmp_en to 0x1E, word 0x1E long -> fault=1, instr_valid never set, FAULT held; jmp_en to 0 clears fault.
- jmp_en asserted in CAPT cycle -> no instr_valid, next fetch address = jmp_addr.
- rstn=0 during STORE -> all outputs at reset values next cycle, mem_rw=1, no st_ack.
